// File: rtl/inst_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - redirect_sel encodings
//   - MIPS R/I/J field bit positions
//   - default reset PC
//   - branch target helper
package inst_pkg;

   localparam logic [1:0] SEL_BR  = 2'b00;
   localparam logic [1:0] SEL_J   = 2'b01;
   localparam logic [1:0] SEL_JR  = 2'b10;
   localparam logic [1:0] SEL_RSV = 2'b11;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_MSB = 10;
   localparam int SHAMT_LSB = 6;
   localparam int FUNC_MSB  = 5;
   localparam int FUNC_LSB  = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int ADDR_MSB  = 25;
   localparam int ADDR_LSB  = 0;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // PC-relative branch: word offset, sign-extended, wraps mod 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                 input logic [15:0] imm);
      return base + {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering {pc, inst} pairs between the ROM and decode.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write i_wdata at the tail
//   i_pop        : drop the head entry
//   i_flush      : empty the FIFO; takes priority over a push
//   i_wdata      : entry to write
//   o_rdata      : head entry, reads as zero while empty
//   o_count      : current occupancy
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_do_push = i_push & (~w_full | i_pop);
   assign w_do_pop  = i_pop & ~w_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC generation, synchronous ROM drive, fetch FIFO,
// valid/ready presentation to decode, field split and change-of-flow handling.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_redirect_*          : single-cycle change-of-flow request and operands
//   o_rom_en, o_rom_addr  : ROM read request (word address)
//   i_rom_data            : ROM data, valid the cycle after o_rom_en
//   o_out_valid/i_out_ready : decode handshake
//   o_out_pc, o_out_pc_new, o_out_inst : presented instruction and its PCs
//   o_op .. o_addr        : R/I/J field slices of o_out_inst
//   o_addr_err            : one-cycle pulse for misaligned jr or reserved select
module inst_fetch_unit
   import inst_pkg::*;
#(
   parameter int unsigned ROM_AW   = 6,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_redirect_valid,
   input  logic [1:0]        i_redirect_sel,
   input  logic [31:0]       i_redirect_pc_base,
   input  logic [15:0]       i_redirect_imm,
   input  logic [25:0]       i_redirect_addr,
   input  logic [31:0]       i_redirect_reg,
   output logic              o_rom_en,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [31:0]       i_rom_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [31:0]       o_out_pc,
   output logic [31:0]       o_out_pc_new,
   output logic [31:0]       o_out_inst,
   output logic [5:0]        o_op,
   output logic [4:0]        o_rs,
   output logic [4:0]        o_rt,
   output logic [4:0]        o_rd,
   output logic [4:0]        o_shamt,
   output logic [5:0]        o_func,
   output logic [15:0]       o_imm,
   output logic [25:0]       o_addr,
   output logic              o_addr_err
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0] r_pc_f;
   logic        r_req_v;
   logic [31:0] r_req_pc;
   logic        r_addr_err;

   logic [CNT_W-1:0] w_count;
   logic [63:0]      w_head;
   logic             w_pop;
   logic [31:0]      w_occ;
   logic             w_redirect;
   logic             w_issue;
   logic [31:0]      w_target;
   logic             w_addr_err;

   assign w_pop = o_out_valid & i_out_ready;

   // Occupancy once the in-flight word lands and this cycle's pop leaves;
   // issuing only below DEPTH guarantees every returned word has a slot.
   assign w_occ = 32'(w_count) + {31'd0, r_req_v} - {31'd0, w_pop};

   // Reserved select reports an error but neither redirects nor flushes.
   assign w_redirect = i_redirect_valid && (i_redirect_sel != SEL_RSV);
   assign w_issue    = !i_rst && !i_redirect_valid && (w_occ < DEPTH);

   always_comb begin
      w_target = r_pc_f;
      case (i_redirect_sel)
         SEL_BR:  w_target = branch_target(i_redirect_pc_base, i_redirect_imm);
         SEL_J:   w_target = {i_redirect_pc_base[31:28], i_redirect_addr, 2'b00};
         SEL_JR:  w_target = {i_redirect_reg[31:2], 2'b00};
         default: w_target = r_pc_f;
      endcase
   end

   assign w_addr_err = i_redirect_valid &&
                       ((i_redirect_sel == SEL_RSV) ||
                        ((i_redirect_sel == SEL_JR) && (i_redirect_reg[1:0] != 2'b00)));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc_f     <= RESET_PC;
         r_req_v    <= 1'b0;
         r_req_pc   <= 32'd0;
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_addr_err;
         if (w_redirect) begin
            r_pc_f  <= w_target;
            r_req_v <= 1'b0;
         end else if (w_issue) begin
            r_pc_f   <= r_pc_f + 32'd4;
            r_req_v  <= 1'b1;
            r_req_pc <= r_pc_f;
         end else begin
            r_req_v <= 1'b0;
         end
      end
   end

   // The in-flight word is dropped by the flush when a redirect is taken.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_req_v),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .i_wdata ({r_req_pc, i_rom_data}),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign o_rom_en     = w_issue;
   assign o_rom_addr   = r_pc_f[ROM_AW+1:2];
   assign o_out_valid  = (w_count != '0);
   assign o_out_pc     = w_head[63:32];
   assign o_out_inst   = w_head[31:0];
   assign o_out_pc_new = o_out_pc + 32'd4;
   assign o_addr_err   = r_addr_err;

   assign o_op    = o_out_inst[OP_MSB:OP_LSB];
   assign o_rs    = o_out_inst[RS_MSB:RS_LSB];
   assign o_rt    = o_out_inst[RT_MSB:RT_LSB];
   assign o_rd    = o_out_inst[RD_MSB:RD_LSB];
   assign o_shamt = o_out_inst[SHAMT_MSB:SHAMT_LSB];
   assign o_func  = o_out_inst[FUNC_MSB:FUNC_LSB];
   assign o_imm   = o_out_inst[IMM_MSB:IMM_LSB];
   assign o_addr  = o_out_inst[ADDR_MSB:ADDR_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a synchronous model ROM.
module tb_inst_fetch_unit;

   localparam int unsigned ROM_AW = 6;
   localparam int unsigned DEPTH  = 2;

   logic              clk;
   logic              rst;
   logic              redirect_valid;
   logic [1:0]        redirect_sel;
   logic [31:0]       redirect_pc_base;
   logic [15:0]       redirect_imm;
   logic [25:0]       redirect_addr;
   logic [31:0]       redirect_reg;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_pc;
   logic [31:0]       out_pc_new;
   logic [31:0]       out_inst;
   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        func;
   logic [15:0]       imm;
   logic [25:0]       addr;
   logic              addr_err;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rom [2**ROM_AW];

   inst_fetch_unit #(
      .ROM_AW   (ROM_AW),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_redirect_valid   (redirect_valid),
      .i_redirect_sel     (redirect_sel),
      .i_redirect_pc_base (redirect_pc_base),
      .i_redirect_imm     (redirect_imm),
      .i_redirect_addr    (redirect_addr),
      .i_redirect_reg     (redirect_reg),
      .o_rom_en           (rom_en),
      .o_rom_addr         (rom_addr),
      .i_rom_data         (rom_data),
      .o_out_valid        (out_valid),
      .i_out_ready        (out_ready),
      .o_out_pc           (out_pc),
      .o_out_pc_new       (out_pc_new),
      .o_out_inst         (out_inst),
      .o_op               (op),
      .o_rs               (rs),
      .o_rt               (rt),
      .o_rd               (rd),
      .o_shamt            (shamt),
      .o_func             (func),
      .o_imm              (imm),
      .o_addr             (addr),
      .o_addr_err         (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 2**ROM_AW; i++) rom[i] = 32'h1000_0000 + 32'(i);
      rom[7] = 32'h8D2A_5543;
   end

   always @(posedge clk) begin
      if (rom_en) rom_data <= rom[rom_addr];
   end

   function automatic logic [31:0] exp_inst(input int k);
      if (k == 7) return 32'h8D2A_5543;
      return 32'h1000_0000 + 32'(k);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_sel = 2'b00; redirect_pc_base = '0;
      redirect_imm = '0; redirect_addr = '0; redirect_reg = '0; out_ready = 1'b1;
      step(); step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (rom_en !== 1'b0) begin n_err++;
         $display("FAIL reset_rom_en: got %b want 0", rom_en); end
      n_vec++; if (addr_err !== 1'b0) begin n_err++;
         $display("FAIL reset_addr_err: got %b want 0", addr_err); end
      n_vec++; if (out_pc !== 32'h0) begin n_err++;
         $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      n_vec++; if (out_inst !== 32'h0) begin n_err++;
         $display("FAIL reset_out_inst: got %h want 0", out_inst); end
      n_vec++; if (out_pc_new !== 32'h4) begin n_err++;
         $display("FAIL reset_pc_new: got %h want 4", out_pc_new); end
   endtask

   // Leaves the bench in the cycle presenting instruction 7 (pc 0x1C).
   task automatic test_stream();
      rst = 1'b0;
      #1;
      n_vec++; if (rom_en !== 1'b1 || rom_addr !== 6'd0) begin n_err++;
         $display("FAIL first_issue: got en=%b addr=%0d want en=1 addr=0", rom_en, rom_addr); end
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++;
         $display("FAIL cycle1_valid: got %b want 0", out_valid); end
      step();
      for (int k = 0; k < 8; k++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== exp_inst(k)) begin
            n_err++;
            $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                     k, out_valid, out_pc, out_inst, 32'(4 * k), exp_inst(k));
         end
         if (k != 7) step();
      end
      n_vec++;
      if (op !== 6'h23 || rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd10 || shamt !== 5'd21 ||
          func !== 6'h03) begin
         n_err++;
         $display("FAIL fields_r: got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 23/9/10/10/21/03",
                  op, rs, rt, rd, shamt, func);
      end
      n_vec++;
      if (imm !== 16'h5543 || addr !== 26'h12A_5543 || out_pc_new !== 32'h20) begin
         n_err++;
         $display("FAIL fields_ij: got imm=%h addr=%h pcn=%h want 5543/12a5543/20",
                  imm, addr, out_pc_new);
      end
   endtask

   // Leaves the bench in the cycle presenting instruction 12 (pc 0x30).
   task automatic test_stall();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 32'h1C || rom_en !== 1'b0 || rom_addr !== 6'd9) begin
            n_err++;
            $display("FAIL stall_%0d: got v=%b pc=%h en=%b addr=%0d want 1/1c/0/9",
                     i, out_valid, out_pc, rom_en, rom_addr);
         end
      end
      out_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * (7 + j)) || out_inst !== exp_inst(7 + j)) begin
            n_err++;
            $display("FAIL resume_%0d: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                     j, out_valid, out_pc, out_inst, 32'(4 * (7 + j)), exp_inst(7 + j));
         end
         step();
      end
   endtask

   // Redirect while popping; the pop completes and wrong-path words never appear.
   task automatic test_branch();
      redirect_valid = 1'b1; redirect_sel = 2'b00; redirect_pc_base = 32'h20;
      redirect_imm = 16'hFFFC;
      #1;
      n_vec++; if (rom_en !== 1'b0) begin n_err++;
         $display("FAIL br_no_issue: got %b want 0", rom_en); end
      step();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'd4) begin n_err++;
         $display("FAIL br_n1: got v=%b en=%b addr=%0d want 0/1/4", out_valid, rom_en, rom_addr); end
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++;
         $display("FAIL br_n2_valid: got %b want 0", out_valid); end
      step();
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_inst !== 32'h1000_0004) begin
         n_err++;
         $display("FAIL br_n3: got v=%b pc=%h inst=%h want 1/10/10000004", out_valid, out_pc,
                  out_inst); end
      step();
      n_vec++; if (out_pc !== 32'h14) begin n_err++;
         $display("FAIL br_n4_pc: got %h want 14", out_pc); end
   endtask

   task automatic test_jump();
      redirect_valid = 1'b1; redirect_sel = 2'b01; redirect_pc_base = 32'h8000_0010;
      redirect_addr = 26'h40;
      step();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (rom_en !== 1'b1 || rom_addr !== 6'd0 || out_valid !== 1'b0) begin n_err++;
         $display("FAIL j_n1: got en=%b addr=%0d v=%b want 1/0/0", rom_en, rom_addr, out_valid); end
      step(); step();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100 || out_inst !== 32'h1000_0000 ||
          out_pc_new !== 32'h8000_0104) begin
         n_err++;
         $display("FAIL j_n3: got v=%b pc=%h inst=%h pcn=%h want 1/80000100/10000000/80000104",
                  out_valid, out_pc, out_inst, out_pc_new);
      end
      step();
      n_vec++; if (out_pc !== 32'h8000_0104 || out_inst !== 32'h1000_0001) begin n_err++;
         $display("FAIL j_n4: got pc=%h inst=%h want 80000104/10000001", out_pc, out_inst); end
   endtask

   task automatic test_jr();
      redirect_valid = 1'b1; redirect_sel = 2'b10; redirect_reg = 32'h0000_0013;
      #1;
      n_vec++; if (addr_err !== 1'b0) begin n_err++;
         $display("FAIL jr_err_early: got %b want 0", addr_err); end
      step();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (addr_err !== 1'b1 || rom_addr !== 6'd4 || out_valid !== 1'b0) begin n_err++;
         $display("FAIL jr_n1: got err=%b addr=%0d v=%b want 1/4/0", addr_err, rom_addr, out_valid);
      end
      step();
      n_vec++; if (addr_err !== 1'b0) begin n_err++;
         $display("FAIL jr_err_pulse: got %b want 0", addr_err); end
      step();
      n_vec++; if (out_pc !== 32'h10 || out_inst !== 32'h1000_0004) begin n_err++;
         $display("FAIL jr_n3: got pc=%h inst=%h want 10/10000004", out_pc, out_inst); end
   endtask

   // Reserved select: error pulse, no flush, order preserved (a bubble is allowed).
   task automatic test_reserved();
      logic [31:0] exp_pc;
      redirect_valid = 1'b1; redirect_sel = 2'b11;
      step();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (addr_err !== 1'b1) begin n_err++;
         $display("FAIL rsv_err: got %b want 1", addr_err); end
      exp_pc = 32'h14;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) begin
            n_vec++; if (out_pc !== exp_pc) begin n_err++;
               $display("FAIL rsv_seq_%0d: got %h want %h", i, out_pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         if (i != 5) step();
      end
      n_vec++; if (exp_pc !== 32'h28) begin n_err++;
         $display("FAIL rsv_count: got next pc %h want 28", exp_pc); end
   endtask

   task automatic test_reset_redirect();
      out_ready = 1'b0;
      step(); step();
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h24) begin n_err++;
         $display("FAIL rr_buffered: got v=%b pc=%h want 1/24", out_valid, out_pc); end
      rst = 1'b1; redirect_valid = 1'b1; redirect_sel = 2'b01; redirect_pc_base = 32'h0;
      redirect_addr = 26'h20;
      step();
      rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'd0 || addr_err !== 1'b0) begin
         n_err++;
         $display("FAIL rr_n1: got v=%b en=%b addr=%0d err=%b want 0/1/0/0",
                  out_valid, rom_en, rom_addr, addr_err);
      end
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++;
         $display("FAIL rr_n2_valid: got %b want 0", out_valid); end
      step();
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin
         n_err++;
         $display("FAIL rr_n3: got v=%b pc=%h inst=%h want 1/0/10000000", out_valid, out_pc,
                  out_inst); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_jump();
      test_jr();
      test_reserved();
      test_reset_redirect();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
